vc_arbiter: RTL
===============

// Module: vc_arbiter
// PURPOSE
//  Schedules the two virtual-channel FIFOs (VC0, VC1) onto the demux feeding destination FIFOs D0/D1.
//  Each cycle it pops at most one word from a VC whose head word's destination FIFO has room,
//  then registers the word and pushes it to D0 or D1. Sits between VC FIFOs and D FIFOs inside PCIe.
//  It also reports link activity (idle/active) for the top-level state machine.
// PARAMETERS
//  WORD_SIZE  6  data word width; bit [WORD_SIZE-2] is the destination select (0 -> D0, 1 -> D1)
//  CNT_W      8  width of per-VC served-word counters
// PORTS
//  clk            in   1          single clock, rising edge
//  reset          in   1          asynchronous, active-high
//  init           in   1          synchronous clear of counters and RR pointer; blocks pops while high
//  vc0_empty      in   1          VC0 FIFO empty
//  vc1_empty      in   1          VC1 FIFO empty
//  vc0_data       in   WORD_SIZE  VC0 head word (first-word fall-through, valid when !vc0_empty)
//  vc1_data       in   WORD_SIZE  VC1 head word (same rule)
//  d0_almost_full in   1          D0 occupancy >= umbral_D_full
//  d1_almost_full in   1          D1 occupancy >= umbral_D_full
//  pop_vc0        out  1          combinational pop to VC0
//  pop_vc1        out  1          combinational pop to VC1
//  push_d0        out  1          registered push to D0
//  push_d1        out  1          registered push to D1
//  data_out       out  WORD_SIZE  registered word for D0/D1
//  active_out     out  1          state == ACTIVE
//  idle_out       out  1          state == IDLE
//  served_vc0     out  CNT_W      words granted from VC0 since reset/init
//  served_vc1     out  CNT_W      words granted from VC1 since reset/init
// BEHAVIOUR
//  - Reset: push_d0/push_d1 = 0, data_out = 0, served_vc* = 0, RR pointer = VC0, state = IDLE (idle_out = 1).
//  - Eligibility: vcN eligible = !vcN_empty && !dK_almost_full, K = vcN_data[WORD_SIZE-2].
//    A blocked VC never blocks the other one (no cross-VC head-of-line blocking).
//  - Grant (combinational, cycle N): at most one of pop_vc0/pop_vc1; none when init = 1 or state = IDLE.
//  - Cycle N+1: data_out <= granted word; push_dK = 1 for exactly one cycle per granted word; else both 0 and data_out holds.
//  - Latency: pop -> push is exactly 1 cycle; throughput is one word per cycle.
//  - almost_full threshold must leave >= 1 free slot: the in-flight word is always pushed.
//  - FSM: IDLE -> ACTIVE when init = 0 and either VC non-empty (grant allowed from first cycle of ACTIVE, i.e. the cycle after).
//         ACTIVE -> IDLE when both VCs empty and no push pending.
//         ACTIVE stays ACTIVE while any VC non-empty, even if all eligible = 0 (stall).
//         Any state -> IDLE when init = 1 (synchronous); counters cleared, RR pointer = VC0; in-flight push still completes.
//  - Counters: served_vcN increments on each pop_vcN, wraps modulo 2^CNT_W with no saturation.
//  - Reset mid-transfer: the in-flight word is dropped; push_d* go low immediately (asynchronous).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: round-robin; pointer moves to the other VC after each grant;
//    if only one VC is eligible, it is granted regardless of the pointer.
//  ARB_ROUND_ROBIN_EN undefined: strict priority; VC0 is granted whenever eligible; VC1 only when VC0 is not eligible.
//    The RR pointer logic is not built.
// STRUCTURE
//  - Shared package pcie_pkg: WORD_SIZE, destination bit index, state encoding
//    (IDLE = 1'b0, ACTIVE = 1'b1), VC id constants.
//  - One sub-module, vc_arb_grant: combinational eligibility + grant, containing the ARB_ROUND_ROBIN_EN variants.
//  - Top holds FSM, output register, counters.
// TESTING
//  1. Reset, then VC0 holds 0x05 (dest D0), VC1 empty
//     -> pop_vc0 = 1 one cycle; next cycle push_d0 = 1, data_out = 0x05; served_vc0 = 1.
//  2. Both VCs hold 3 words each, all destined to D1, D FIFOs never full
//     -> RR: grants alternate 0,1,0,1,0,1; strict: 0,0,0,1,1,1. One push_d1 per cycle, 6 total.
//  3. VC0 head dest D0 with d0_almost_full = 1; VC1 head 0x10 (dest D1)
//     -> VC1 popped; push_d1 with 0x10; VC0 held until d0_almost_full = 0, then popped.
//  4. Both VCs empty after traffic
//     -> idle_out = 1 the cycle after the last push.
//     -> init pulse: counters = 0, and no pops while init = 1 even with data present.
//  5. Assert reset during the cycle after pop_vc1
//     -> push_d1 = 0 and data_out = 0 immediately; state IDLE; served_vc1 = 0.
//  6. Push 256 words through VC0 with CNT_W = 8 -> served_vc0 wraps to 0.

Source files
------------

// File: rtl/pcie_pkg.sv
// Shared constants and types for the PCIe virtual-channel arbiter slice.
// The ARB_ROUND_ROBIN_EN macro selects the arbitration policy in vc_arb_grant and vc_arbiter.
package pcie_pkg;

  localparam int WORD_SIZE = 6;
  localparam int DEST_BIT  = WORD_SIZE - 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_e;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  // Destination-select bit position for a given word width.
  function automatic int dest_bit(input int ws);
    return ws - 2;
  endfunction

endpackage

// File: rtl/vc_arb_grant.sv
// Combinational eligibility check and single-winner grant between VC0 and VC1.
// ARB_ROUND_ROBIN_EN defined: round-robin on rr_ptr; undefined: VC0 strict priority.
module vc_arb_grant #(
  parameter int WORD_SIZE = pcie_pkg::WORD_SIZE
) (
  input  logic                 en,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [WORD_SIZE-1:0] vc0_data,
  input  logic [WORD_SIZE-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic                 rr_ptr,
`endif
  output logic                 pop_vc0,
  output logic                 pop_vc1
);
  import pcie_pkg::*;

  localparam int DEST = dest_bit(WORD_SIZE);

  logic elig0;
  logic elig1;

  // Each VC looks only at the D FIFO its own head word targets, so one blocked VC never stalls the other.
  assign elig0 = !vc0_empty && !(vc0_data[DEST] ? d1_almost_full : d0_almost_full);
  assign elig1 = !vc1_empty && !(vc1_data[DEST] ? d1_almost_full : d0_almost_full);

  always_comb begin
    pop_vc0 = 1'b0;
    pop_vc1 = 1'b0;
    if (en) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (elig0 && elig1) begin
        pop_vc0 = (rr_ptr == VC0);
        pop_vc1 = (rr_ptr == VC1);
      end else begin
        pop_vc0 = elig0;
        pop_vc1 = elig1;
      end
`else
      pop_vc0 = elig0;
      pop_vc1 = elig1 && !elig0;
`endif
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Schedules VC0/VC1 FIFO heads onto the D0/D1 demux with a one-cycle registered push.
// ARB_ROUND_ROBIN_EN defined builds the round-robin pointer; otherwise VC0 has strict priority.
module vc_arbiter #(
  parameter int WORD_SIZE = pcie_pkg::WORD_SIZE,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [WORD_SIZE-1:0] vc0_data,
  input  logic [WORD_SIZE-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 active_out,
  output logic                 idle_out,
  output logic [CNT_W-1:0]     served_vc0,
  output logic [CNT_W-1:0]     served_vc1
);
  import pcie_pkg::*;

  localparam int DEST = dest_bit(WORD_SIZE);

  arb_state_e           state_q, state_d;
  logic                 grant_en;
  logic                 pop_any;
  logic [WORD_SIZE-1:0] word_sel;
  logic                 push_d0_q, push_d1_q;
  logic [WORD_SIZE-1:0] data_q;
  logic [CNT_W-1:0]     served_vc0_q, served_vc0_d;
  logic [CNT_W-1:0]     served_vc1_q, served_vc1_d;

  assign grant_en = (state_q == ACTIVE) && !init;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr_q, rr_ptr_d;

  // Pointer favours the VC that was not served last.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (init)         rr_ptr_d = VC0;
    else if (pop_vc0) rr_ptr_d = VC1;
    else if (pop_vc1) rr_ptr_d = VC0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= VC0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  vc_arb_grant #(.WORD_SIZE(WORD_SIZE)) u_grant (
    .en             (grant_en),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr         (rr_ptr_q),
`endif
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1)
  );

  assign pop_any  = pop_vc0 || pop_vc1;
  assign word_sel = pop_vc1 ? vc1_data : vc0_data;

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!vc0_empty || !vc1_empty) state_d = ACTIVE;
        ACTIVE:  if (vc0_empty && vc1_empty && !pop_any) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    served_vc0_d = served_vc0_q + CNT_W'(pop_vc0);
    served_vc1_d = served_vc1_q + CNT_W'(pop_vc1);
    if (init) begin
      served_vc0_d = '0;
      served_vc1_d = '0;
    end
  end

  // The word granted now is pushed next cycle even if init rises meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      push_d0_q    <= 1'b0;
      push_d1_q    <= 1'b0;
      data_q       <= '0;
      served_vc0_q <= '0;
      served_vc1_q <= '0;
    end else begin
      state_q      <= state_d;
      push_d0_q    <= pop_any && !word_sel[DEST];
      push_d1_q    <= pop_any && word_sel[DEST];
      if (pop_any) data_q <= word_sel;
      served_vc0_q <= served_vc0_d;
      served_vc1_q <= served_vc1_d;
    end
  end

  assign push_d0    = push_d0_q;
  assign push_d1    = push_d1_q;
  assign data_out   = data_q;
  assign active_out = (state_q == ACTIVE);
  assign idle_out   = (state_q == IDLE);
  assign served_vc0 = served_vc0_q;
  assign served_vc1 = served_vc1_q;

endmodule
